// File: rtl/control_transfer_sequencer_if.sv
// ----------------------------------------------------------------------------
// control_transfer_sequencer_if
//
// Purpose: bundles the decode-stage inputs and the pipeline control outputs
// of the control transfer sequencer.
//
// Signals:
//   dec_valid, dec_call, dec_ret, dec_rti      decode slot contents
//   dec_uses_rsrc, dec_uses_rdst               operand usage of decode slot
//   dec_rsrc_addr, dec_rdst_addr [2:0]         decode register addresses
//   ex_mem_read, ex_rdst_addr [2:0]            load/pop currently in ID/EX
//   int_req                                    external interrupt level
//   stall, bubble, flush                       pipeline hold/kill controls
//   uop_valid, uop_push, uop_pop, word_sel     stack micro-op for ID/EX
//   pc_load, pc_sel                            fetch PC mux control
//   int_ack, busy                              status
//
// Modports:
//   master - pipeline side (drives decode inputs, consumes controls)
//   slave  - sequencer side
//
// Handshake: there is no back-pressure. uop_valid=1 means the micro-op
// fields (uop_push/uop_pop/word_sel) are meaningful in that same cycle and
// must be taken by ID/EX in place of the decoded instruction.
// ----------------------------------------------------------------------------
interface control_transfer_sequencer_if;
    logic       dec_valid;
    logic       dec_call;
    logic       dec_ret;
    logic       dec_rti;
    logic       dec_uses_rsrc;
    logic       dec_uses_rdst;
    logic [2:0] dec_rsrc_addr;
    logic [2:0] dec_rdst_addr;
    logic       ex_mem_read;
    logic [2:0] ex_rdst_addr;
    logic       int_req;

    logic       stall;
    logic       bubble;
    logic       uop_valid;
    logic       uop_push;
    logic       uop_pop;
    logic [1:0] word_sel;
    logic       pc_load;
    logic [1:0] pc_sel;
    logic       flush;
    logic       int_ack;
    logic       busy;

    modport master (
        output dec_valid, dec_call, dec_ret, dec_rti,
        output dec_uses_rsrc, dec_uses_rdst, dec_rsrc_addr, dec_rdst_addr,
        output ex_mem_read, ex_rdst_addr, int_req,
        input  stall, bubble, uop_valid, uop_push, uop_pop, word_sel,
        input  pc_load, pc_sel, flush, int_ack, busy
    );

    modport slave (
        input  dec_valid, dec_call, dec_ret, dec_rti,
        input  dec_uses_rsrc, dec_uses_rdst, dec_rsrc_addr, dec_rdst_addr,
        input  ex_mem_read, ex_rdst_addr, int_req,
        output stall, bubble, uop_valid, uop_push, uop_pop, word_sel,
        output pc_load, pc_sel, flush, int_ack, busy
    );
endinterface

// File: rtl/control_transfer_sequencer.sv
// ----------------------------------------------------------------------------
// control_transfer_sequencer
//
// Purpose: decode-stage sequencer. Expands CALL, RET, RTI and interrupt entry
// into ordered 16-bit stack micro-ops (PC high word, PC low word, flags),
// detects load-use hazards and owns stall/bubble/flush/PC-load controls.
//
// Parameters:
//   MEM_LAT   cycles from a pop leaving decode until its data reaches
//             writeback (1..7)
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   bus        control_transfer_sequencer_if.slave (decode inputs, controls)
//   dbg_state  current FSM state encoding
//
// All control outputs are combinational from the state (plus decode inputs
// while idle) and are forced to 0 while rst_n is low.
// ----------------------------------------------------------------------------
module control_transfer_sequencer #(
    parameter int unsigned MEM_LAT = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    control_transfer_sequencer_if.slave   bus,
    output logic [3:0]                    dbg_state
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_C_HI   = 4'd1,
        S_C_LO   = 4'd2,
        S_R_HI   = 4'd3,
        S_R_LO   = 4'd4,
        S_WAIT   = 4'd5,
        S_LOAD   = 4'd6,
        S_RT_FLG = 4'd7,
        S_I_HI   = 4'd8,
        S_I_LO   = 4'd9,
        S_I_FLG  = 4'd10,
        S_I_VEC  = 4'd11
    } state_t;

    localparam logic [1:0] WS_PC_HI  = 2'b00;
    localparam logic [1:0] WS_PC_LO  = 2'b01;
    localparam logic [1:0] WS_FLAGS  = 2'b10;
    localparam logic [1:0] PS_POPPED = 2'b01;
    localparam logic [1:0] PS_CALL   = 2'b10;
    localparam logic [1:0] PS_VECTOR = 2'b11;
    localparam logic [2:0] WAIT_INIT = 3'(MEM_LAT - 1);

    state_t     state;
    state_t     state_nx;
    logic [2:0] wait_cnt;
    logic       int_prev;
    logic       int_pending;
    logic       int_edge;
    logic       haz;

    logic       o_stall, o_bubble, o_uop_valid, o_uop_push, o_uop_pop;
    logic [1:0] o_word_sel, o_pc_sel;
    logic       o_pc_load, o_flush, o_int_ack;

    assign int_edge = bus.int_req & ~int_prev;

    assign haz = bus.ex_mem_read & bus.dec_valid &
                 ((bus.dec_uses_rsrc & (bus.ex_rdst_addr == bus.dec_rsrc_addr)) |
                  (bus.dec_uses_rdst & (bus.ex_rdst_addr == bus.dec_rdst_addr)));

    always_comb begin
        state_nx    = state;
        o_stall     = 1'b0;
        o_bubble    = 1'b0;
        o_uop_valid = 1'b0;
        o_uop_push  = 1'b0;
        o_uop_pop   = 1'b0;
        o_word_sel  = WS_PC_HI;
        o_pc_load   = 1'b0;
        o_pc_sel    = 2'b00;
        o_flush     = 1'b0;
        o_int_ack   = 1'b0;
        // Reset gates every output, including the hazard path in IDLE.
        if (rst_n) begin
            case (state)
                S_IDLE: begin
                    if (haz) begin
                        o_stall  = 1'b1;
                        o_bubble = 1'b1;
                    end else if (bus.dec_valid & bus.dec_call) begin
                        o_stall  = 1'b1;
                        o_bubble = 1'b1;
                        state_nx = S_C_HI;
                    end else if (bus.dec_valid & bus.dec_ret) begin
                        o_stall  = 1'b1;
                        o_bubble = 1'b1;
                        state_nx = S_R_HI;
                    end else if (bus.dec_valid & bus.dec_rti) begin
                        o_stall  = 1'b1;
                        o_bubble = 1'b1;
                        state_nx = S_RT_FLG;
                    end else if (int_pending) begin
                        o_stall   = 1'b1;
                        o_bubble  = 1'b1;
                        o_int_ack = 1'b1;
                        state_nx  = S_I_HI;
                    end
                end
                S_C_HI: begin
                    {o_uop_valid, o_uop_push, o_stall} = 3'b111;
                    o_word_sel = WS_PC_HI;
                    state_nx   = S_C_LO;
                end
                S_C_LO: begin
                    {o_uop_valid, o_uop_push} = 2'b11;
                    o_word_sel = WS_PC_LO;
                    o_pc_load  = 1'b1;
                    o_pc_sel   = PS_CALL;
                    o_flush    = 1'b1;
                    state_nx   = S_IDLE;
                end
                S_RT_FLG: begin
                    {o_uop_valid, o_uop_pop, o_stall} = 3'b111;
                    o_word_sel = WS_FLAGS;
                    state_nx   = S_R_HI;
                end
                S_R_HI: begin
                    {o_uop_valid, o_uop_pop, o_stall} = 3'b111;
                    o_word_sel = WS_PC_HI;
                    state_nx   = S_R_LO;
                end
                S_R_LO: begin
                    {o_uop_valid, o_uop_pop, o_stall} = 3'b111;
                    o_word_sel = WS_PC_LO;
                    state_nx   = S_WAIT;
                end
                S_WAIT: begin
                    // Holds until the popped PC words have reached writeback.
                    o_stall  = 1'b1;
                    o_bubble = 1'b1;
                    if (wait_cnt == 3'd0) state_nx = S_LOAD;
                end
                S_LOAD: begin
                    o_pc_load = 1'b1;
                    o_pc_sel  = PS_POPPED;
                    o_flush   = 1'b1;
                    state_nx  = S_IDLE;
                end
                S_I_HI: begin
                    {o_uop_valid, o_uop_push, o_stall} = 3'b111;
                    o_word_sel = WS_PC_HI;
                    state_nx   = S_I_LO;
                end
                S_I_LO: begin
                    {o_uop_valid, o_uop_push, o_stall} = 3'b111;
                    o_word_sel = WS_PC_LO;
                    state_nx   = S_I_FLG;
                end
                S_I_FLG: begin
                    {o_uop_valid, o_uop_push, o_stall} = 3'b111;
                    o_word_sel = WS_FLAGS;
                    state_nx   = S_I_VEC;
                end
                S_I_VEC: begin
                    o_pc_load = 1'b1;
                    o_pc_sel  = PS_VECTOR;
                    o_flush   = 1'b1;
                    state_nx  = S_IDLE;
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            wait_cnt    <= 3'd0;
            int_prev    <= 1'b0;
            int_pending <= 1'b0;
        end else begin
            state    <= state_nx;
            int_prev <= bus.int_req;
            // A new edge in the acknowledge cycle keeps the request pending.
            int_pending <= int_edge | (int_pending & ~o_int_ack);
            if (state == S_R_LO) begin
                wait_cnt <= WAIT_INIT;
            end else if ((state == S_WAIT) && (wait_cnt != 3'd0)) begin
                wait_cnt <= wait_cnt - 3'd1;
            end
        end
    end

    assign bus.stall     = o_stall;
    assign bus.bubble    = o_bubble;
    assign bus.uop_valid = o_uop_valid;
    assign bus.uop_push  = o_uop_push;
    assign bus.uop_pop   = o_uop_pop;
    assign bus.word_sel  = o_word_sel;
    assign bus.pc_load   = o_pc_load;
    assign bus.pc_sel    = o_pc_sel;
    assign bus.flush     = o_flush;
    assign bus.int_ack   = o_int_ack;
    assign bus.busy      = rst_n & (state != S_IDLE);
    assign dbg_state     = state;

endmodule

// File: tb/tb_control_transfer_sequencer.sv
// ----------------------------------------------------------------------------
// tb_control_transfer_sequencer
//
// Two sequencers (MEM_LAT=2 and MEM_LAT=1) share one set of inputs. A
// reference model expands each accepted instruction into its per-cycle
// output script and queues it; while a script is queued the model ignores
// decode inputs, otherwise it applies the idle priority rules.
// Output vector bit order:
//   {stall, bubble, uop_valid, uop_push, uop_pop, word_sel[1:0],
//    pc_load, pc_sel[1:0], flush, int_ack, busy}
// ----------------------------------------------------------------------------
module tb_control_transfer_sequencer;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    control_transfer_sequencer_if ifc0 ();
    control_transfer_sequencer_if ifc1 ();

    assign ifc1.dec_valid     = ifc0.dec_valid;
    assign ifc1.dec_call      = ifc0.dec_call;
    assign ifc1.dec_ret       = ifc0.dec_ret;
    assign ifc1.dec_rti       = ifc0.dec_rti;
    assign ifc1.dec_uses_rsrc = ifc0.dec_uses_rsrc;
    assign ifc1.dec_uses_rdst = ifc0.dec_uses_rdst;
    assign ifc1.dec_rsrc_addr = ifc0.dec_rsrc_addr;
    assign ifc1.dec_rdst_addr = ifc0.dec_rdst_addr;
    assign ifc1.ex_mem_read   = ifc0.ex_mem_read;
    assign ifc1.ex_rdst_addr  = ifc0.ex_rdst_addr;
    assign ifc1.int_req       = ifc0.int_req;

    logic [3:0] dbg0, dbg1;

    control_transfer_sequencer #(.MEM_LAT(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(ifc0), .dbg_state(dbg0)
    );
    control_transfer_sequencer #(.MEM_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(ifc1), .dbg_state(dbg1)
    );

    logic [12:0] got0, got1;
    assign got0 = {ifc0.stall, ifc0.bubble, ifc0.uop_valid, ifc0.uop_push, ifc0.uop_pop,
                   ifc0.word_sel, ifc0.pc_load, ifc0.pc_sel, ifc0.flush, ifc0.int_ack, ifc0.busy};
    assign got1 = {ifc1.stall, ifc1.bubble, ifc1.uop_valid, ifc1.uop_push, ifc1.uop_pop,
                   ifc1.word_sel, ifc1.pc_load, ifc1.pc_sel, ifc1.flush, ifc1.int_ack, ifc1.busy};

    // ---------------- output vector fields ----------------
    localparam logic [12:0] B_STALL  = 13'h1000;
    localparam logic [12:0] B_BUBBLE = 13'h0800;
    localparam logic [12:0] B_UV     = 13'h0400;
    localparam logic [12:0] B_PUSH   = 13'h0200;
    localparam logic [12:0] B_POP    = 13'h0100;
    localparam logic [12:0] WS_HI    = 13'h0000;
    localparam logic [12:0] WS_LO    = 13'h0040;
    localparam logic [12:0] WS_FLG   = 13'h0080;
    localparam logic [12:0] B_PCL    = 13'h0020;
    localparam logic [12:0] PS_POP   = 13'h0008;
    localparam logic [12:0] PS_CALL  = 13'h0010;
    localparam logic [12:0] PS_VEC   = 13'h0018;
    localparam logic [12:0] B_FLUSH  = 13'h0004;
    localparam logic [12:0] B_ACK    = 13'h0002;
    localparam logic [12:0] B_BUSY   = 13'h0001;

    localparam int K_CALL = 0;
    localparam int K_RET  = 1;
    localparam int K_RTI  = 2;
    localparam int K_INT  = 3;

    // ---------------- scoreboard state ----------------
    logic [12:0] exp_q0[$];
    logic [12:0] exp_q1[$];
    logic        m_pend[2];
    logic        m_prev;
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic q_push(input int inst, input logic [12:0] v);
        if (inst == 0) exp_q0.push_back(v);
        else           exp_q1.push_back(v);
    endtask

    // PC words popped, MEM_LAT cycles of stall+bubble, then PC load.
    task automatic ret_tail(input int inst, input int lat);
        q_push(inst, B_BUSY | B_STALL | B_UV | B_POP | WS_HI);
        q_push(inst, B_BUSY | B_STALL | B_UV | B_POP | WS_LO);
        for (int i = 0; i < lat; i++) q_push(inst, B_BUSY | B_STALL | B_BUBBLE);
        q_push(inst, B_BUSY | B_PCL | PS_POP | B_FLUSH);
    endtask

    task automatic push_script(input int inst, input int kind);
        int lat;
        lat = (inst == 0) ? 2 : 1;
        case (kind)
            K_CALL: begin
                q_push(inst, B_BUSY | B_STALL | B_UV | B_PUSH | WS_HI);
                q_push(inst, B_BUSY | B_UV | B_PUSH | WS_LO | B_PCL | PS_CALL | B_FLUSH);
            end
            K_RET: ret_tail(inst, lat);
            K_RTI: begin
                q_push(inst, B_BUSY | B_STALL | B_UV | B_POP | WS_FLG);
                ret_tail(inst, lat);
            end
            default: begin
                q_push(inst, B_BUSY | B_STALL | B_UV | B_PUSH | WS_HI);
                q_push(inst, B_BUSY | B_STALL | B_UV | B_PUSH | WS_LO);
                q_push(inst, B_BUSY | B_STALL | B_UV | B_PUSH | WS_FLG);
                q_push(inst, B_BUSY | B_PCL | PS_VEC | B_FLUSH);
            end
        endcase
    endtask

    task automatic model_reset();
        exp_q0.delete();
        exp_q1.delete();
        m_pend[0] = 1'b0;
        m_pend[1] = 1'b0;
        m_prev    = 1'b0;
    endtask

    task automatic model_inst(input int inst, input logic [12:0] got, output logic ack);
        logic [12:0] e;
        logic        haz;
        int          qs;
        ack = 1'b0;
        qs  = (inst == 0) ? exp_q0.size() : exp_q1.size();
        if (qs != 0) begin
            e = (inst == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        end else begin
            haz = ifc0.ex_mem_read && ifc0.dec_valid &&
                  ((ifc0.dec_uses_rsrc && ifc0.ex_rdst_addr == ifc0.dec_rsrc_addr) ||
                   (ifc0.dec_uses_rdst && ifc0.ex_rdst_addr == ifc0.dec_rdst_addr));
            if (haz) begin
                e = B_STALL | B_BUBBLE;
            end else if (ifc0.dec_valid && ifc0.dec_call) begin
                e = B_STALL | B_BUBBLE;
                push_script(inst, K_CALL);
            end else if (ifc0.dec_valid && ifc0.dec_ret) begin
                e = B_STALL | B_BUBBLE;
                push_script(inst, K_RET);
            end else if (ifc0.dec_valid && ifc0.dec_rti) begin
                e = B_STALL | B_BUBBLE;
                push_script(inst, K_RTI);
            end else if (m_pend[inst]) begin
                e   = B_STALL | B_BUBBLE | B_ACK;
                ack = 1'b1;
                push_script(inst, K_INT);
            end else begin
                e = 13'h0;
            end
        end
        check_eq($sformatf("out_L%0d_c%0d", (inst == 0) ? 2 : 1, cyc), 16'(got), 16'(e));
    endtask

    // One clock: compare at the falling edge, return just after the next
    // rising edge so callers drive the following cycle's inputs.
    task automatic run_cycle();
        logic a0, a1, int_rise;
        @(negedge clk);
        cyc++;
        if (!rst_n) begin
            check_eq($sformatf("rst_L2_c%0d", cyc), 16'(got0), 16'h0);
            check_eq($sformatf("rst_L1_c%0d", cyc), 16'(got1), 16'h0);
            model_reset();
        end else begin
            model_inst(0, got0, a0);
            model_inst(1, got1, a1);
            int_rise  = ifc0.int_req & ~m_prev;
            m_pend[0] = int_rise | (m_pend[0] & ~a0);
            m_pend[1] = int_rise | (m_pend[1] & ~a1);
            m_prev    = ifc0.int_req;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) run_cycle();
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_dec();
        ifc0.dec_valid     = 1'b0;
        ifc0.dec_call      = 1'b0;
        ifc0.dec_ret       = 1'b0;
        ifc0.dec_rti       = 1'b0;
        ifc0.dec_uses_rsrc = 1'b0;
        ifc0.dec_uses_rdst = 1'b0;
        ifc0.dec_rsrc_addr = 3'd0;
        ifc0.dec_rdst_addr = 3'd0;
        ifc0.ex_mem_read   = 1'b0;
        ifc0.ex_rdst_addr  = 3'd0;
    endtask

    task automatic drive_kind(input int kind);
        clear_dec();
        ifc0.dec_valid = 1'b1;
        ifc0.dec_call  = (kind == K_CALL);
        ifc0.dec_ret   = (kind == K_RET);
        ifc0.dec_rti   = (kind == K_RTI);
    endtask

    task automatic drive_random();
        int r;
        ifc0.dec_valid     = ($urandom_range(0, 9) < 7);
        r                  = $urandom_range(0, 11);
        ifc0.dec_call      = (r == 0);
        ifc0.dec_ret       = (r == 1);
        ifc0.dec_rti       = (r == 2);
        ifc0.dec_uses_rsrc = $urandom_range(0, 1) != 0;
        ifc0.dec_uses_rdst = $urandom_range(0, 1) != 0;
        ifc0.dec_rsrc_addr = 3'($urandom_range(0, 3));
        ifc0.dec_rdst_addr = 3'($urandom_range(0, 3));
        ifc0.ex_mem_read   = ($urandom_range(0, 3) == 0);
        ifc0.ex_rdst_addr  = 3'($urandom_range(0, 3));
        if ($urandom_range(0, 5) == 0) ifc0.int_req = ~ifc0.int_req;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        clear_dec();
        rst_n = 1'b0;
        // Hazard inputs and a held interrupt level while in reset.
        ifc0.int_req       = 1'b1;
        ifc0.dec_valid     = 1'b1;
        ifc0.dec_uses_rsrc = 1'b1;
        ifc0.ex_mem_read   = 1'b1;
        ifc0.ex_rdst_addr  = 3'd3;
        ifc0.dec_rsrc_addr = 3'd3;
        @(posedge clk);
        #1;
        run_n(2);

        // Level high out of reset is taken as an edge -> interrupt entry.
        rst_n = 1'b1;
        clear_dec();
        run_n(8);
        ifc0.int_req = 1'b0;
        run_n(2);

        // Load-use hazard for one cycle, then cleared.
        ifc0.dec_valid     = 1'b1;
        ifc0.dec_uses_rsrc = 1'b1;
        ifc0.dec_rsrc_addr = 3'd3;
        ifc0.ex_mem_read   = 1'b1;
        ifc0.ex_rdst_addr  = 3'd3;
        run_cycle();
        ifc0.ex_mem_read = 1'b0;
        run_cycle();
        clear_dec();

        // CALL with an interrupt edge arriving at T1.
        drive_kind(K_CALL);
        run_cycle();
        clear_dec();
        ifc0.int_req = 1'b1;
        run_cycle();
        ifc0.int_req = 1'b0;
        run_n(8);

        // RET and RTI.
        drive_kind(K_RET);
        run_cycle();
        clear_dec();
        run_n(7);
        drive_kind(K_RTI);
        run_cycle();
        clear_dec();
        run_n(8);

        // Interrupt edge in the same cycle as int_ack.
        drive_kind(K_CALL);
        ifc0.int_req = 1'b1;
        run_cycle();
        clear_dec();
        run_cycle();
        ifc0.int_req = 1'b0;
        run_cycle();
        ifc0.int_req = 1'b1;
        run_cycle();
        run_n(10);
        ifc0.int_req = 1'b0;
        run_n(2);

        // Reset pulsed in the middle of the RET wait.
        drive_kind(K_RET);
        run_cycle();
        clear_dec();
        run_n(3);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_L2", 16'(got0), 16'h0);
        check_eq("async_rst_L1", 16'(got1), 16'h0);
        model_reset();
        run_cycle();
        rst_n = 1'b1;
        run_n(3);

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            drive_random();
            run_cycle();
        end
        clear_dec();
        ifc0.int_req = 1'b0;
        run_n(12);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
